// File: rtl/conv_result_writer.sv
// conv_result_writer
// Collects nine beats of 3x3 convolution partial sums into per-pixel
// accumulators, then writes the rounded, rescaled tile into the result RAM
// one pixel per cycle in row-major order.
// Build option: define CONV_WR_SAT_EN to saturate results to 16 bits
// instead of wrapping them.

module conv_result_writer #(
    parameter int FRAC_SHIFT = 10,
    parameter int ACC_W      = 36
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  tile_row,
    input  logic [4:0]  tile_col,
    input  logic        p_valid,
    input  logic [31:0] p1,
    input  logic [31:0] p2,
    input  logic [31:0] p3,
    input  logic [31:0] p4,
    input  logic [31:0] p5,
    input  logic [31:0] p6,
    input  logic [31:0] p7,
    input  logic [31:0] p8,
    input  logic [31:0] p9,
    output logic        w_en,
    output logic [4:0]  add_row,
    output logic [4:0]  add_col,
    output logic [15:0] w_data,
    output logic        busy,
    output logic        done,
    output logic        ovf_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ROUND_HALF =
        {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

    state_t state_q;
    state_t state_d;
    logic   last_write;

    logic signed [ACC_W-1:0] acc_q [9];
    logic [31:0]             p_in  [9];
    logic [3:0]              beat_cnt_q;
    logic [3:0]              idx_q;
    logic [1:0]              row_off_q;
    logic [1:0]              col_off_q;
    logic [4:0]              tile_row_q;
    logic [4:0]              tile_col_q;
    logic                    done_q;
    logic                    ovf_q;

    logic signed [ACC_W-1:0] sel_acc;
    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] shifted;
    logic [15:0]             result16;

    assign p_in[0] = p1;
    assign p_in[1] = p2;
    assign p_in[2] = p3;
    assign p_in[3] = p4;
    assign p_in[4] = p5;
    assign p_in[5] = p6;
    assign p_in[6] = p7;
    assign p_in[7] = p8;
    assign p_in[8] = p9;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping start always wins and abandons the job
    always_comb begin
        state_d    = state_q;
        last_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!start) begin
                    state_d = IDLE;
                end else if (p_valid && (beat_cnt_q == 4'd8)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!start) begin
                    state_d = IDLE;
                end else if (idx_q == 4'd8) begin
                    state_d    = IDLE;
                    last_write = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Accumulators, beat/write counters, tile origin and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 9; k++) begin
                acc_q[k] <= '0;
            end
            beat_cnt_q <= '0;
            idx_q      <= '0;
            row_off_q  <= '0;
            col_off_q  <= '0;
            tile_row_q <= '0;
            tile_col_q <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= last_write;
            if (p_valid && (state_q != ACCUM)) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tile_row_q <= tile_row;
                        tile_col_q <= tile_col;
                        for (int k = 0; k < 9; k++) begin
                            acc_q[k] <= '0;
                        end
                        beat_cnt_q <= '0;
                        idx_q      <= '0;
                        row_off_q  <= '0;
                        col_off_q  <= '0;
                    end
                end
                ACCUM: begin
                    if (!start) begin
                        for (int k = 0; k < 9; k++) begin
                            acc_q[k] <= '0;
                        end
                        beat_cnt_q <= '0;
                    end else if (p_valid) begin
                        for (int k = 0; k < 9; k++) begin
                            acc_q[k] <= acc_q[k] +
                                {{(ACC_W-32){p_in[k][31]}}, p_in[k]};
                        end
                        beat_cnt_q <= beat_cnt_q + 4'd1;
                    end
                end
                WRITE: begin
                    if (!start || (idx_q == 4'd8)) begin
                        for (int k = 0; k < 9; k++) begin
                            acc_q[k] <= '0;
                        end
                        beat_cnt_q <= '0;
                        idx_q      <= '0;
                        row_off_q  <= '0;
                        col_off_q  <= '0;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                        if (col_off_q == 2'd2) begin
                            col_off_q <= '0;
                            row_off_q <= row_off_q + 2'd1;
                        end else begin
                            col_off_q <= col_off_q + 2'd1;
                        end
                    end
                end
                default: begin
                    beat_cnt_q <= '0;
                end
            endcase
        end
    end

    // Pick the accumulator for the current write slot and round half up
    always_comb begin
        sel_acc = '0;
        for (int k = 0; k < 9; k++) begin
            if (idx_q == 4'(k)) begin
                sel_acc = acc_q[k];
            end
        end
        rounded = sel_acc + ROUND_HALF;
        shifted = rounded >>> FRAC_SHIFT;
    end

`ifdef CONV_WR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    // Clamp the rescaled value into the signed 16-bit range
    always_comb begin
        if (shifted > SAT_MAX) begin
            result16 = 16'h7FFF;
        end else if (shifted < SAT_MIN) begin
            result16 = 16'h8000;
        end else begin
            result16 = shifted[15:0];
        end
    end
`else
    logic unused_hi_bits;

    assign unused_hi_bits = ^shifted[ACC_W-1:16];

    // Keep the low 16 bits; out-of-range results wrap
    always_comb begin
        result16 = shifted[15:0];
    end
`endif

    // RAM-side outputs are only non-zero while writing
    always_comb begin
        w_en    = 1'b0;
        add_row = '0;
        add_col = '0;
        w_data  = '0;
        if (state_q == WRITE) begin
            w_en    = 1'b1;
            add_row = tile_row_q + {3'b000, row_off_q};
            add_col = tile_col_q + {3'b000, col_off_q};
            w_data  = result16;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign ovf_err = ovf_q;

endmodule

// File: doc/conv_result_writer.md
CONV_RESULT_WRITER -- requirements
Module: conv_result_writer

Interface
REQ-001 Parameter FRAC_SHIFT, default 10: right-shift applied to the accumulated sum (Q6.10 weight scaling).
REQ-002 Parameter ACC_W, default 36: accumulator width in bits, signed.
REQ-003 clk  input  1  single clock; all state on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; high arms and holds a tile job, low aborts it.
REQ-006 tile_row, tile_col  input  5 each  top-left RAM address of the 3x3 output tile.
REQ-007 p_valid  input  1  beat qualifier for p1..p9.
REQ-008 p1..p9  input  32 each  signed partial results from the convolution engine, row-major over the 3x3 tile.
REQ-009 w_en  output  1  result RAM write enable.
REQ-010 add_row, add_col  output  5 each  result RAM write address.
REQ-011 w_data  output  16  signed result word.
REQ-012 busy  output  1  high in ACCUM or WRITE.
REQ-013 done  output  1  one-cycle pulse after the last write.
REQ-014 ovf_err  output  1  sticky protocol error flag.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM and WRITE.
REQ-016 In IDLE with start=1, it SHALL latch tile_row/tile_col, clear acc1..acc9 and beat count, and go to ACCUM on the next edge.
REQ-017 In ACCUM, each cycle with p_valid=1 SHALL add sign-extended pk into acck (k=1..9) and increment the beat count; p_valid=0 SHALL hold state.
REQ-018 On the 9th accepted beat, the FSM SHALL go to WRITE on the following edge; the 9th beat is included in the sums.
REQ-019 WRITE SHALL last exactly 9 cycles, with index i=0..8, w_en=1, add_row=(tile_row+i/3) mod 32 and add_col=(tile_col+i%3) mod 32.
REQ-020 w_data in WRITE SHALL be round(acc(i+1) / 2^FRAC_SHIFT), rounding half toward +infinity: add 2^(FRAC_SHIFT-1), then arithmetic shift.
REQ-021 First write SHALL occur in the cycle after the edge that accepted the 9th beat; latency from 9th beat to last write is 9 cycles.
REQ-022 After the 9th write, done SHALL pulse for 1 cycle and the FSM SHALL return to IDLE; a new job needs start=1 in IDLE (start held high re-arms immediately).
REQ-023 p_valid=1 during WRITE or IDLE SHALL be ignored and SHALL set ovf_err.
REQ-024 start=0 during ACCUM or WRITE SHALL abort to IDLE on the next edge: w_en=0, no done, accumulators cleared.
REQ-025 Outside WRITE, w_en=0 and add_row, add_col and w_data SHALL be 0.
REQ-026 Accumulator overflow beyond ACC_W SHALL wrap silently.

Reset
REQ-027 When reset=0, state=IDLE, all acck=0, beat count=0, w_en=0, add_row=0, add_col=0, w_data=0, busy=0, done=0 and ovf_err=0, independent of clk.
REQ-028 Reset asserted mid-job SHALL discard the job with no further writes; ovf_err is cleared only by reset.

Configuration
REQ-029 With CONV_WR_SAT_EN defined, the shifted result SHALL saturate to [-32768, 32767] before driving w_data.
REQ-030 Without CONV_WR_SAT_EN, w_data SHALL be bits [15:0] of the shifted result (two's-complement wrap).

Verification
REQ-031 Tile (4,7); 9 beats with all pk=1024 -> 9 writes of 9 at (4,7)..(6,9) row-major, then done pulses once.
REQ-032 Tile (30,31); one beat with p5=1536, other beats 0 -> w_data=2 at i=4 (rounded from 1.5), address (31,0) via wrap; all others 0.
REQ-033 9 beats with p1=32'h7FFFFFFF -> with CONV_WR_SAT_EN first write 32767; without it first write equals the low 16 bits of the shifted sum.
REQ-034 start dropped after beat 5 -> no w_en, no done; a restart with 9 beats of pk=1024 yields 9, showing no residue from the aborted job.
REQ-035 p_valid pulsed in IDLE and in WRITE -> ovf_err=1 and stays high; write data unchanged; reset=0 clears the flag.
REQ-036 Gapped p_valid (beats spaced 1-3 idle cycles) -> same results as back-to-back beats; busy high from the ACCUM entry edge to the last write.
